// File: rtl/ppu_pkg.sv
// ppu_pkg: VGA 640x480@60 timing, NES frame geometry and the RGB444 pixel type.
package ppu_pkg;
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int X_OFS  = 64;
  localparam int NES_W  = 256;
  localparam int NES_H  = 240;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;
endpackage

// File: rtl/ppu_nes_palette_rom.sv
// ppu_nes_palette_rom: 2C02 palette quantised to RGB444, one-cycle registered lookup.
module ppu_nes_palette_rom
  import ppu_pkg::*;
(
  input  logic       i_clk,
  input  logic [5:0] idx_i,
  output rgb444_t    rgb_o
);
  localparam logic [11:0] PAL [64] = '{
    12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
    12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
    12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
    12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
    12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
  };
  always_ff @(posedge i_clk) rgb_o <= rgb444_t'(PAL[idx_i]);
endmodule

// File: rtl/ppu_vout_scan.sv
// ppu_vout_scan: scans the double-buffered NES frame at 2x into centred 640x480 VGA with palette lookup.
module ppu_vout_scan #(
  parameter int H_VIS  = ppu_pkg::H_VIS,
  parameter int H_FP   = ppu_pkg::H_FP,
  parameter int H_SYNC = ppu_pkg::H_SYNC,
  parameter int H_BP   = ppu_pkg::H_BP,
  parameter int V_VIS  = ppu_pkg::V_VIS,
  parameter int V_FP   = ppu_pkg::V_FP,
  parameter int V_SYNC = ppu_pkg::V_SYNC,
  parameter int V_BP   = ppu_pkg::V_BP,
  parameter int X_OFS  = ppu_pkg::X_OFS
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_ena,
  output logic [16:0] o_vbuf_addr,
  output logic        o_vbuf_re,
  input  logic [7:0]  i_vbuf_rdata,
  input  logic        i_frame_done,
  output logic        o_wr_bank,
  output logic        o_vblank,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [11:0] o_rgb
);
  import ppu_pkg::rgb444_t;
  localparam logic [9:0] HVIS  = 10'(H_VIS);
  localparam logic [9:0] HS0   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS1   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] HLAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VVIS  = 10'(V_VIS);
  localparam logic [9:0] VS0   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS1   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] VLAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] XL    = 10'(X_OFS);
  localparam logic [9:0] XR    = 10'(X_OFS + 2 * ppu_pkg::NES_W);
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        rd_bank_q, rd_bank_d, pend_q, pend_d;
  logic [16:0] addr_q, addr_d;
  logic [2:0]  img_q, vis_q, hs_q, vs_q;
  logic        vis, img, hs, vs, swap;
  logic [7:0]  hx;
  rgb444_t     pal;
  logic        unused_rdata;
  always_comb begin
    vis       = hcnt_q < HVIS && vcnt_q < VVIS;
    img       = vis && hcnt_q >= XL && hcnt_q < XR;
    hs        = hcnt_q >= HS0 && hcnt_q < HS1;
    vs        = vcnt_q >= VS0 && vcnt_q < VS1;
    hx        = 8'((hcnt_q - XL) >> 1);
    swap      = i_ena && hcnt_q == '0 && vcnt_q == VVIS;
    hcnt_d    = (!i_ena || hcnt_q == HLAST) ? '0 : hcnt_q + 10'd1;
    vcnt_d    = !i_ena ? '0 : hcnt_q != HLAST ? vcnt_q : vcnt_q == VLAST ? '0 : vcnt_q + 10'd1;
    rd_bank_d = rd_bank_q ^ (swap && (pend_q || i_frame_done));
    pend_d    = !swap && (pend_q || i_frame_done);
    addr_d    = (i_ena && img) ? {rd_bank_q, vcnt_q[8:1], hx} : '0;
  end
  // Delay lines align sync/DE with the RAM read plus palette register (3 cycles).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      rd_bank_q <= 1'b0;
      pend_q    <= 1'b0;
      addr_q    <= '0;
      img_q     <= '0;
      vis_q     <= '0;
      hs_q      <= '0;
      vs_q      <= '0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      rd_bank_q <= rd_bank_d;
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      img_q     <= i_ena ? {img_q[1:0], img} : '0;
      vis_q     <= i_ena ? {vis_q[1:0], vis} : '0;
      hs_q      <= i_ena ? {hs_q[1:0], hs} : '0;
      vs_q      <= i_ena ? {vs_q[1:0], vs} : '0;
    end
  end
  ppu_nes_palette_rom u_pal (.i_clk(i_clk), .idx_i(i_vbuf_rdata[5:0]), .rgb_o(pal));
  assign unused_rdata = ^i_vbuf_rdata[7:6];
  assign o_vbuf_addr  = addr_q;
  assign o_vbuf_re    = img_q[0];
  assign o_wr_bank    = ~rd_bank_q;
  assign o_vblank     = vcnt_q >= VVIS;
  assign o_hsync      = ~hs_q[2];
  assign o_vsync      = ~vs_q[2];
  assign o_de         = vis_q[2];
  assign o_rgb        = img_q[2] ? pal : '0;
endmodule

// File: tb/tb_ppu_vout_scan.sv
// tb_ppu_vout_scan: frame-level model with per-cycle compare plus directed timing, window, bank and reset checks.
module tb_ppu_vout_scan;
  localparam int VV = 8, VF = 2, VS = 2, VB = 2, VT = VV + VF + VS + VB, HT = 800;
  localparam logic [11:0] PAL [64] = '{
    12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
    12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
    12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
    12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
    12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
  };
  typedef struct packed {
    logic        img, de, hs, vs;
    logic [16:0] addr;
    logic [11:0] rgb;
  } pix_t;
  logic        clk = 0, rstn = 0, ena = 1, fd = 0;
  logic [7:0]  rdata;
  logic [16:0] addr;
  logic        re, wr_bank, vblank, hsync, vsync, de;
  logic [11:0] rgb;
  int          n_chk = 0, n_err = 0;
  int          mh = 0, mv = 0;
  logic        mb = 0, mp = 0;
  pix_t        h1 = '0, h2 = '0, h3 = '0;

  ppu_vout_scan #(.V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_ena(ena), .o_vbuf_addr(addr), .o_vbuf_re(re),
    .i_vbuf_rdata(rdata), .i_frame_done(fd), .o_wr_bank(wr_bank), .o_vblank(vblank),
    .o_hsync(hsync), .o_vsync(vsync), .o_de(de), .o_rgb(rgb)
  );

  initial forever #5 clk = ~clk;

  // Frame buffer content: colour index depends on x, y and bank; top bits set to prove they are ignored.
  always @(posedge clk) rdata <= {2'b11, 6'(addr[7:0] + 3 * addr[15:8] + 5 * addr[16] + 22)};

  function automatic pix_t pix(int h, int v, logic b);
    pix_t p = '0;
    int x = (h - 64) / 2, y = v / 2;
    p.de  = h < 640 && v < VV;
    p.img = p.de && h >= 64 && h < 576;
    p.hs  = h >= 656 && h < 752;
    p.vs  = v >= VV + VF && v < VV + VF + VS;
    if (p.img) begin
      p.addr = {b, 8'(y), 8'(x)};
      p.rgb  = PAL[(x + 3 * y + 5 * b + 22) % 64];
    end
    return p;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mh <= 0; mv <= 0; mb <= 0; mp <= 0; h1 <= '0; h2 <= '0; h3 <= '0;
    end else begin
      h1 <= ena ? pix(mh, mv, mb) : '0;
      h2 <= ena ? h1 : '0;
      h3 <= ena ? h2 : '0;
      if (ena && mh == 0 && mv == VV) begin
        mb <= mb ^ (mp | fd);
        mp <= 0;
      end else mp <= mp | fd;
      mh <= ena ? (mh + 1) % HT : 0;
      mv <= !ena ? 0 : mh == HT - 1 ? (mv + 1) % VT : mv;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", nm, act, exp, mh, mv, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("addr", 32'(addr), 32'(h1.addr));
    chk("re", 32'(re), 32'(h1.img));
    chk("de", 32'(de), 32'(h3.de));
    chk("hsync", 32'(hsync), 32'(!h3.hs));
    chk("vsync", 32'(vsync), 32'(!h3.vs));
    chk("rgb", 32'(rgb), 32'(h3.rgb));
    chk("vblank", 32'(vblank), 32'(mv >= VV));
    chk("wr_bank", 32'(wr_bank), 32'(!mb));
  end

  task automatic wait_at(input int h, input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mh == h && mv == v) && n < 20000);
    if (n >= 20000) chk("wait_timeout", 32'(n), 32'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_re"}, 32'(re), 0);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 1);
    chk({tag, "_vblank"}, 32'(vblank), 0);
    chk({tag, "_de"}, 32'(de), 0);
    chk({tag, "_rgb"}, 32'(rgb), 0);
    chk({tag, "_hsync"}, 32'(hsync), 1);
    chk({tag, "_vsync"}, 32'(vsync), 1);
  endtask

  initial begin
    int hs_n, vs_n, de_n, vb_n, first_h;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst0");
    rstn = 1;
    // Pixel path and borders on line 0 of frame 0 (bank 0).
    wait_at(66, 0);
    chk("border_rgb", 32'(rgb), 0);
    @(negedge clk);
    chk("px00_rgb", 32'(rgb), 32'h0F30);
    chk("px00_de", 32'(de), 1);
    // Two renderer pulses before the swap collapse into one.
    wait_at(100, 3); fd = 1; @(negedge clk); fd = 0;
    wait_at(100, 5); fd = 1; @(negedge clk); fd = 0;
    wait_at(64, 7);
    chk("re_h63", 32'(re), 0);
    @(negedge clk); chk("addr_h64", 32'(addr), 32'h00300);
    @(negedge clk); chk("addr_h65", 32'(addr), 32'h00300);
    @(negedge clk); chk("addr_h66", 32'(addr), 32'h00301);
    @(negedge clk); chk("addr_h67", 32'(addr), 32'h00301);
    wait_at(576, 7); chk("re_h575", 32'(re), 1);
    @(negedge clk); chk("re_h576", 32'(re), 0);
    wait_at(799, 7);
    chk("vblank_pre", 32'(vblank), 0);
    @(negedge clk);
    chk("vblank_rise", 32'(vblank), 1);
    chk("wr_bank_pre", 32'(wr_bank), 1);
    @(negedge clk);
    chk("wr_bank_swap", 32'(wr_bank), 0);
    // Frame 1: free-run statistics, no pulse so no swap.
    wait_at(0, 0);
    hs_n = 0; vs_n = 0; de_n = 0; vb_n = 0; first_h = -1;
    for (int i = 0; i < HT * VT; i++) begin
      hs_n += int'(!hsync);
      vs_n += int'(!vsync);
      de_n += int'(de);
      vb_n += int'(vblank);
      if (!hsync && first_h < 0) first_h = mh;
      if (mh == 67 && mv == 0) chk("px00_bank1_rgb", 32'(rgb), 32'h00A4);
      if (mh == 1 && mv == VV) chk("wr_bank_noswap", 32'(wr_bank), 0);
      @(negedge clk);
    end
    chk("hsync_low_cycles", 32'(hs_n), 96 * VT);
    chk("hsync_first_h", 32'(first_h), 659);
    chk("vsync_low_cycles", 32'(vs_n), 2 * HT);
    chk("de_cycles", 32'(de_n), 640 * VV);
    chk("vblank_cycles", 32'(vb_n), (VT - VV) * HT);
    // Frame 2: pulse exactly at the swap cycle.
    wait_at(0, VV);
    fd = 1; @(negedge clk); fd = 0;
    chk("wr_bank_same_cycle", 32'(wr_bank), 1);
    // Frame 3: drop enable mid-line.
    wait_at(400, 5);
    ena = 0;
    repeat (10) @(negedge clk);
    chk("ena_de", 32'(de), 0);
    chk("ena_re", 32'(re), 0);
    chk("ena_rgb", 32'(rgb), 0);
    chk("ena_hsync", 32'(hsync), 1);
    chk("ena_vblank", 32'(vblank), 0);
    chk("ena_wr_bank", 32'(wr_bank), 1);
    ena = 1;
    wait_at(67, 0);
    chk("restart_rgb", 32'(rgb), 32'h0F30);
    // Asynchronous reset mid-frame.
    wait_at(300, 2);
    chk("pre_rst_de", 32'(de), 1);
    #2 rstn = 0;
    #1 chk_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    rstn = 1;
    repeat (2000) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
